// File: rtl/frame_rx.sv
// frame_rx: K.28.1 preamble hunt, 4-byte CRC strip and per-frame verdict.
// Optional FRAME_RX_STATS_EN adds good_cnt/bad_cnt frame counters.
module frame_rx #(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_k,
  output logic [7:0]  crc_in,
  output logic        crc_in_valid,
  input  logic [31:0] crc_out,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic [15:0] frame_len
`ifdef FRAME_RX_STATS_EN
  ,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
`endif
);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHECK
  } state_t;

  localparam logic [15:0] MAX = 16'(MAX_LEN);

  state_t          state;
  logic [3:0][7:0] sr;
  logic [2:0]      fill;
  logic [1:0]      comma_cnt;
  logic [15:0]     payload_cnt;

  logic       is_comma;
  logic       is_eof;
  logic       full;
  logic       crc_match;
  logic       abort;
  logic [1:0] abort_code;
  logic       emit;
  logic       shift;
  logic       to_check;

  assign is_comma  = rx_k && rx_data == 8'h3C;
  assign is_eof    = rx_k && rx_data == 8'hBC;
  assign full      = fill == 3'd4;
  // sr[3] holds the first CRC byte received, sr[0] the last
  assign crc_match = {sr[0], sr[1], sr[2], sr[3]} == crc_out;
  assign pl_data   = crc_in;
  assign pl_valid  = crc_in_valid;

  always_comb begin
    abort      = 1'b0;
    abort_code = 2'd0;
    emit       = 1'b0;
    shift      = 1'b0;
    to_check   = 1'b0;
    if (state == DATA) begin
      unique case (1'b1)
        !rx_k: begin
          if (full && payload_cnt == MAX) begin
            abort      = 1'b1;
            abort_code = 2'd2;
          end else begin
            shift = 1'b1;
            emit  = full;
          end
        end
        is_comma && fill == 3'd0 && payload_cnt == 16'd0: begin
        end
        is_eof: begin
          if (!full || payload_cnt == 16'd0) begin
            abort      = 1'b1;
            abort_code = 2'd1;
          end else begin
            to_check = 1'b1;
          end
        end
        default: begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      sr           <= '0;
      fill         <= 3'd0;
      comma_cnt    <= 2'd0;
      payload_cnt  <= 16'd0;
      crc_in       <= 8'd0;
      crc_in_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      err_code     <= 2'd0;
      frame_len    <= 16'd0;
    end else begin
      crc_in_valid <= emit;
      frame_done   <= abort || state == CHECK;
      if (shift)
        sr <= {sr[2:0], rx_data};
      if (shift && !full)
        fill <= fill + 3'd1;
      if (emit) begin
        crc_in      <= sr[3];
        payload_cnt <= payload_cnt + 16'd1;
      end
      if (to_check)
        state <= CHECK;
      if (abort) begin
        state       <= HUNT;
        fill        <= 3'd0;
        payload_cnt <= 16'd0;
        comma_cnt   <= 2'd0;
        frame_ok    <= 1'b0;
        err_code    <= abort_code;
        frame_len   <= payload_cnt;
      end
      // CHECK keeps counting commas so a preamble can follow EOF directly
      if (state != DATA) begin
        if (state == CHECK) begin
          state     <= HUNT;
          frame_ok  <= crc_match;
          err_code  <= 2'd0;
          frame_len <= payload_cnt;
        end
        if (!is_comma) begin
          comma_cnt <= 2'd0;
        end else if (comma_cnt == 2'd3) begin
          state       <= DATA;
          comma_cnt   <= 2'd0;
          fill        <= 3'd0;
          payload_cnt <= 16'd0;
        end else begin
          comma_cnt <= comma_cnt + 2'd1;
        end
      end
    end
  end

`ifdef FRAME_RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt <= 32'd0;
      bad_cnt  <= 32'd0;
    end else if (state == CHECK && crc_match) begin
      good_cnt <= good_cnt + 32'd1;
    end else if (abort || state == CHECK) begin
      bad_cnt <= bad_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: random frames vs. a frame-level reference model,
// with a behavioural CRC-32 engine feeding crc_out.
module tb_frame_rx;

  localparam int ML = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_k;
  logic [7:0]  crc_in;
  logic        crc_in_valid;
  logic [31:0] crc_out;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] frame_len;
`ifdef FRAME_RX_STATS_EN
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;
`endif

  frame_rx #(.MAX_LEN(ML)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_k(rx_k),
    .crc_in(crc_in),
    .crc_in_valid(crc_in_valid),
    .crc_out(crc_out),
    .pl_data(pl_data),
    .pl_valid(pl_valid),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .err_code(err_code),
    .frame_len(frame_len)
`ifdef FRAME_RX_STATS_EN
    ,
    .good_cnt(good_cnt),
    .bad_cnt(bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } eb_t;

  typedef struct {
    logic        ok;
    logic [1:0]  err;
    logic [15:0] len;
    int          c;
  } done_t;

  localparam logic [7:0] ILL [8] = '{8'h1C, 8'h5C, 8'h7C, 8'h9C,
                                     8'hDC, 8'hFC, 8'hF7, 8'hFB};

  eb_t        exp_b[$];
  done_t      exp_d[$];
  logic [8:0] body[$];
  eb_t        eb;
  done_t      ed;
  int         total = 0;
  int         bad_n = 0;
  int         exp_good = 0;
  int         exp_bad = 0;
  int         cyc = 0;
  bit         skip = 1'b0;
  logic       prev_done = 1'b0;
  logic [31:0] eng;

  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] b);
    c = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_step(c, q[i]);
    return ~c;
  endfunction

  // CRC engine: absorbs each valid byte, restarts after each verdict
  always @(posedge clk or posedge reset) begin
    if (reset) eng <= 32'hFFFFFFFF;
    else if (crc_in_valid) eng <= crc_step(eng, crc_in);
    else if (frame_done) eng <= 32'hFFFFFFFF;
  end
  assign crc_out = ~eng;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("pl_mirror", {23'd0, pl_valid, pl_data},
            {23'd0, crc_in_valid, crc_in});
      if (frame_done)
        check("done_gap", {31'd0, prev_done}, 32'd0);
      if (!skip && crc_in_valid) begin
        if (exp_b.size() == 0) begin
          total++;
          bad_n++;
          $display("FAIL extra_byte: got %0h want none", crc_in);
        end else begin
          eb = exp_b.pop_front();
          check("payload", {24'd0, crc_in}, {24'd0, eb.d});
          check("byte_cycle", cyc, eb.c);
        end
      end
      if (!skip && frame_done) begin
        if (exp_d.size() == 0) begin
          total++;
          bad_n++;
          $display("FAIL extra_done: got ok=%0d want none", frame_ok);
        end else begin
          ed = exp_d.pop_front();
          check("frame_ok", {31'd0, frame_ok}, {31'd0, ed.ok});
          if (!ed.ok)
            check("err_code", {30'd0, err_code}, {30'd0, ed.err});
          check("frame_len", {16'd0, frame_len}, {16'd0, ed.len});
          check("done_cycle", cyc, ed.c);
        end
      end
    end
    prev_done <= frame_done;
  end

  task automatic put(input logic [8:0] t);
    rx_k    = t[8];
    rx_data = t[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic push_done(input logic ok, input logic [1:0] err,
                           input int len, input int c);
    done_t d;
    d.ok  = ok;
    d.err = err;
    d.len = 16'(len);
    d.c   = c;
    exp_d.push_back(d);
    if (ok) exp_good++;
    else exp_bad++;
  endtask

  // Frame-level reference: collect bytes, last four are the CRC
  task automatic model(input logic [8:0] full[$], input int s,
                       input int base);
    logic [7:0] got[$];
    logic [7:0] pay[$];
    eb_t        e;
    int         n;
    for (int i = s; i < full.size(); i++) begin
      n = got.size();
      if (!full[i][8]) begin
        got.push_back(full[i][7:0]);
        if (got.size() > ML + 4) begin
          push_done(1'b0, 2'd2, ML, base + i + 1);
          return;
        end
        if (got.size() > 4) begin
          e.d = got[got.size() - 5];
          e.c = base + i + 1;
          exp_b.push_back(e);
        end
      end else if (full[i][7:0] == 8'h3C && n == 0) begin
      end else if (full[i][7:0] == 8'hBC) begin
        if (n <= 4) begin
          push_done(1'b0, 2'd1, 0, base + i + 1);
        end else begin
          for (int j = 0; j < n - 4; j++) pay.push_back(got[j]);
          push_done(crc32(pay) == {got[n-1], got[n-2], got[n-3], got[n-4]},
                    2'd0, n - 4, base + i + 2);
        end
        return;
      end else begin
        push_done(1'b0, 2'd3, n > 4 ? n - 4 : 0, base + i + 1);
        return;
      end
    end
  endtask

  task automatic send(input int gap, input int extra);
    logic [8:0] full[$];
    int         s;
    for (int i = 0; i < gap; i++)
      full.push_back($urandom_range(0, 3) == 0 ? 9'h1BC
                                               : {1'b0, 8'($urandom)});
    repeat (4) full.push_back(9'h13C);
    s = full.size();
    repeat (extra) full.push_back(9'h13C);
    foreach (body[i]) full.push_back(body[i]);
    body.delete();
    model(full, s, cyc);
    foreach (full[i]) put(full[i]);
  endtask

  task automatic add_digits();
    for (int i = 1; i <= 9; i++) body.push_back({1'b0, 8'(8'h30 + i)});
  endtask

  task automatic rand_frame();
    int          kind;
    int          n;
    logic [7:0]  pay[$];
    logic [31:0] c;
    kind = $urandom_range(0, 5);
    case (kind)
      0, 1, 2: begin
        n = $urandom_range(1, ML);
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        c = crc32(pay);
        if (kind == 2) c = c ^ (32'h1 << $urandom_range(0, 31));
        foreach (pay[i]) body.push_back({1'b0, pay[i]});
        for (int i = 0; i < 4; i++) body.push_back({1'b0, c[8*i +: 8]});
        body.push_back(9'h1BC);
      end
      3: begin
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) body.push_back({1'b0, 8'($urandom)});
        body.push_back(9'h1BC);
      end
      4: begin
        n = $urandom_range(ML + 5, ML + 8);
        for (int i = 0; i < n; i++) body.push_back({1'b0, 8'($urandom)});
        body.push_back(9'h1BC);
      end
      default: begin
        n = $urandom_range(0, 10);
        for (int i = 0; i < n; i++) body.push_back({1'b0, 8'($urandom)});
        if (n > 0 && $urandom_range(0, 3) == 0) body.push_back(9'h13C);
        else body.push_back({1'b1, ILL[$urandom_range(0, 7)]});
      end
    endcase
    send($urandom_range(0, 3), $urandom_range(0, 2));
  endtask

  initial begin
    reset   = 1'b1;
    rx_k    = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", {14'd0, crc_in, crc_in_valid, pl_data, pl_valid},
          32'd0);
    check("rst_b", {12'd0, frame_done, frame_ok, err_code, frame_len},
          32'd0);
    reset = 1'b0;

    add_digits();
    body.push_back(9'h026); body.push_back(9'h039);
    body.push_back(9'h0F4); body.push_back(9'h0CB);
    body.push_back(9'h1BC);
    send(2, 0);

    add_digits();
    body.push_back(9'h026); body.push_back(9'h039);
    body.push_back(9'h0F4); body.push_back(9'h0CA);
    body.push_back(9'h1BC);
    send(0, 0);

    body.push_back(9'h011); body.push_back(9'h022);
    body.push_back(9'h033); body.push_back(9'h1BC);
    send(1, 0);

    for (int i = 0; i < ML + 7; i++) body.push_back({1'b0, 8'(i + 1)});
    body.push_back(9'h1BC);
    send(0, 1);

    for (int i = 1; i <= 4; i++) body.push_back({1'b0, 8'(8'h30 + i)});
    body.push_back(9'h11C);
    send(0, 0);
    add_digits();
    body.push_back(9'h026); body.push_back(9'h039);
    body.push_back(9'h0F4); body.push_back(9'h0CB);
    body.push_back(9'h1BC);
    send(0, 1);

    repeat (4) put(9'h055);
    check("pre_reset_q", exp_b.size() + exp_d.size(), 0);
    skip = 1'b1;
    repeat (4) put(9'h13C);
    for (int i = 0; i < 7; i++) put({1'b0, 8'(8'hA0 + i)});
    rx_k    = 1'b0;
    rx_data = 8'h00;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_a", {14'd0, crc_in, crc_in_valid, pl_data, pl_valid},
          32'd0);
    check("mid_rst_b", {12'd0, frame_done, frame_ok, err_code, frame_len},
          32'd0);
    exp_good = 0;
    exp_bad  = 0;
    skip     = 1'b0;
    add_digits();
    body.push_back(9'h026); body.push_back(9'h039);
    body.push_back(9'h0F4); body.push_back(9'h0CB);
    body.push_back(9'h1BC);
    send(1, 0);

    repeat (60) rand_frame();

    repeat (12) put(9'h000);
    check("bytes_left", exp_b.size(), 0);
    check("dones_left", exp_d.size(), 0);
`ifdef FRAME_RX_STATS_EN
    check("good_cnt", good_cnt, exp_good);
    check("bad_cnt", bad_cnt, exp_bad);
`endif
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule
